cep_axil2wb_bridge: RTL and testbench

Parametrised AXI4-lite slave to classic Wishbone master bridge, the successor to the fixed 32-bit pipelined converter used in front of the CEP Wishbone cores (RSA, AES, SHA, etc.). It adds:
- configurable data width;
- independent AW/W/AR holding registers with read/write fairness arbitration;
- a Wishbone bus-hang timeout that returns SLVERR;
- a synchronised Wishbone reset output.

It sits between the system AXI4-lite interconnect and one Wishbone core per instance.

---
 rtl/cep_axil2wb_bridge.sv | 220 ++++++++++++++++++++++
 tb/tb_cep_axil2wb_bridge.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cep_axil2wb_bridge.sv
// AXI4-lite slave to classic Wishbone master bridge with per-channel holding
// registers, read/write fairness, bus-hang timeout and a synchronised WB reset.
module cep_axil2wb_bridge #(
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int C_AXI_ADDR_WIDTH = 32,
  parameter int C_WB_TIMEOUT     = 255
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [C_AXI_ADDR_WIDTH-1:0]        i_axi_awaddr,
  input  logic [2:0]                         i_axi_awprot,
  input  logic                               i_axi_awvalid,
  output logic                               o_axi_awready,
  input  logic [C_AXI_DATA_WIDTH-1:0]        i_axi_wdata,
  input  logic [C_AXI_DATA_WIDTH/8-1:0]      i_axi_wstrb,
  input  logic                               i_axi_wvalid,
  output logic                               o_axi_wready,
  output logic [1:0]                         o_axi_bresp,
  output logic                               o_axi_bvalid,
  input  logic                               i_axi_bready,
  input  logic [C_AXI_ADDR_WIDTH-1:0]        i_axi_araddr,
  input  logic [2:0]                         i_axi_arprot,
  input  logic                               i_axi_arvalid,
  output logic                               o_axi_arready,
  output logic [C_AXI_DATA_WIDTH-1:0]        o_axi_rdata,
  output logic [1:0]                         o_axi_rresp,
  output logic                               o_axi_rvalid,
  input  logic                               i_axi_rready,
  output logic                               o_wb_rst,
  output logic                               o_wb_cyc,
  output logic                               o_wb_stb,
  output logic                               o_wb_we,
  output logic [C_AXI_ADDR_WIDTH-$clog2(C_AXI_DATA_WIDTH/8)-1:0] o_wb_adr,
  output logic [C_AXI_DATA_WIDTH-1:0]        o_wb_dat,
  output logic [C_AXI_DATA_WIDTH/8-1:0]      o_wb_sel,
  input  logic [C_AXI_DATA_WIDTH-1:0]        i_wb_dat,
  input  logic                               i_wb_ack,
  input  logic                               i_wb_err,
  output logic                               o_timeout
);
  localparam int DW = C_AXI_DATA_WIDTH;
  localparam int SW = DW / 8;
  localparam int SL = $clog2(SW);
  localparam int WA = C_AXI_ADDR_WIDTH - SL;
  localparam logic [15:0] TMO = 16'(C_WB_TIMEOUT);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  typedef enum logic [2:0] {S_IDLE, S_WB_WR, S_WB_RD, S_RESP_B, S_RESP_R} state_e;
  state_e state_q, state_d;

  logic [1:0]    rst_sync_q;
  logic          aw_full_q, w_full_q, ar_full_q;
  logic [WA-1:0] awaddr_q, araddr_q;
  logic [DW-1:0] wdata_q;
  logic [SW-1:0] wstrb_q;
  logic          last_op_q;
  logic [15:0]   cnt_q;
  logic [1:0]    resp_q;
  logic [DW-1:0] rdata_q;
  logic [WA-1:0] wb_adr_q;
  logic [DW-1:0] wb_dat_q;
  logic [SW-1:0] wb_sel_q;
  logic          timeout_q;

  logic aw_hs, w_hs, ar_hs, wr_rdy, tmo_hit;
  logic issue_wr, issue_rd, term, term_err, term_tmo;

  // Prot and sub-word address bits carry no meaning for a word-addressed core.
  logic unused_bits;
  assign unused_bits = ^{i_axi_awprot, i_axi_arprot, i_axi_awaddr[SL-1:0], i_axi_araddr[SL-1:0]};

  // Reset asserts asynchronously and releases after two clean edges.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rst_sync_q <= 2'b00;
    else         rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign o_wb_rst = ~rst_sync_q[1];

  assign o_axi_awready = ~aw_full_q & ~o_wb_rst;
  assign o_axi_wready  = ~w_full_q  & ~o_wb_rst;
  assign o_axi_arready = ~ar_full_q & ~o_wb_rst;
  assign aw_hs  = i_axi_awvalid & o_axi_awready;
  assign w_hs   = i_axi_wvalid  & o_axi_wready;
  assign ar_hs  = i_axi_arvalid & o_axi_arready;
  assign wr_rdy = aw_full_q & w_full_q;
  assign tmo_hit = (TMO != 16'd0) && (cnt_q == TMO);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    issue_wr = 1'b0;
    issue_rd = 1'b0;
    term     = 1'b0;
    term_err = 1'b0;
    term_tmo = 1'b0;
    case (state_q)
      S_IDLE: begin
        // On a tie the channel that did not go last wins.
        if (wr_rdy && (!ar_full_q || last_op_q == OP_READ)) begin
          issue_wr = 1'b1;
          state_d  = (wstrb_q == '0) ? S_RESP_B : S_WB_WR;
        end else if (ar_full_q) begin
          issue_rd = 1'b1;
          state_d  = S_WB_RD;
        end
      end
      S_WB_WR, S_WB_RD: begin
        if (i_wb_err) begin
          term     = 1'b1;
          term_err = 1'b1;
        end else if (i_wb_ack) begin
          term = 1'b1;
        end else if (tmo_hit) begin
          term     = 1'b1;
          term_tmo = 1'b1;
        end
        if (term) state_d = (state_q == S_WB_WR) ? S_RESP_B : S_RESP_R;
      end
      S_RESP_B: if (i_axi_bready) state_d = S_IDLE;
      S_RESP_R: if (i_axi_rready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    o_wb_cyc     = 1'b0;
    o_wb_stb     = 1'b0;
    o_wb_we      = 1'b0;
    o_axi_bvalid = 1'b0;
    o_axi_rvalid = 1'b0;
    case (state_q)
      S_WB_WR: begin
        o_wb_cyc = 1'b1;
        o_wb_stb = 1'b1;
        o_wb_we  = 1'b1;
      end
      S_WB_RD: begin
        o_wb_cyc = 1'b1;
        o_wb_stb = 1'b1;
      end
      S_RESP_B: o_axi_bvalid = 1'b1;
      S_RESP_R: o_axi_rvalid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      aw_full_q <= 1'b0;
      w_full_q  <= 1'b0;
      ar_full_q <= 1'b0;
      awaddr_q  <= '0;
      araddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      last_op_q <= OP_READ;
      cnt_q     <= '0;
      resp_q    <= RESP_OKAY;
      rdata_q   <= '0;
      wb_adr_q  <= '0;
      wb_dat_q  <= '0;
      wb_sel_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      // Flags drop at issue so the channels can refill while the cycle runs.
      if (issue_wr) aw_full_q <= 1'b0;
      else if (aw_hs) begin
        aw_full_q <= 1'b1;
        awaddr_q  <= i_axi_awaddr[C_AXI_ADDR_WIDTH-1:SL];
      end
      if (issue_wr) w_full_q <= 1'b0;
      else if (w_hs) begin
        w_full_q <= 1'b1;
        wdata_q  <= i_axi_wdata;
        wstrb_q  <= i_axi_wstrb;
      end
      if (issue_rd) ar_full_q <= 1'b0;
      else if (ar_hs) begin
        ar_full_q <= 1'b1;
        araddr_q  <= i_axi_araddr[C_AXI_ADDR_WIDTH-1:SL];
      end

      timeout_q <= term_tmo;
      if (issue_wr || issue_rd) cnt_q <= '0;
      else if (o_wb_cyc)        cnt_q <= cnt_q + 16'd1;

      if (issue_wr) begin
        last_op_q <= OP_WRITE;
        wb_adr_q  <= awaddr_q;
        wb_dat_q  <= wdata_q;
        wb_sel_q  <= wstrb_q;
        resp_q    <= RESP_OKAY;
      end
      if (issue_rd) begin
        last_op_q <= OP_READ;
        wb_adr_q  <= araddr_q;
        wb_sel_q  <= '1;
      end
      if (term) begin
        resp_q <= (term_err || term_tmo) ? RESP_SLVERR : RESP_OKAY;
        if (state_q == S_WB_RD) rdata_q <= (term_err || term_tmo) ? '0 : i_wb_dat;
      end
    end
  end

  assign o_axi_bresp = resp_q;
  assign o_axi_rresp = resp_q;
  assign o_axi_rdata = rdata_q;
  assign o_wb_adr    = wb_adr_q;
  assign o_wb_dat    = wb_dat_q;
  assign o_wb_sel    = wb_sel_q;
  assign o_timeout   = timeout_q;
endmodule

// File: tb/tb_cep_axil2wb_bridge.sv
// Directed bench: 32-bit bridge (timeout 15) driven from a vector table plus
// hand sequences for arbitration, reset, and a 64-bit address-mapping instance.
`timescale 1ns/1ps
module tb_cep_axil2wb_bridge;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_ni;

  logic [31:0] awaddr, araddr, wdata, rdata, wb_odat, wb_idat;
  logic [3:0]  wstrb, wb_sel;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;
  logic        wb_rst, wb_cyc, wb_stb, wb_we, wb_ack, wb_err, tmo;
  logic [29:0] wb_adr;

  cep_axil2wb_bridge #(.C_AXI_DATA_WIDTH(32), .C_AXI_ADDR_WIDTH(32), .C_WB_TIMEOUT(15)) u_dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .i_axi_awaddr(awaddr), .i_axi_awprot(3'b000), .i_axi_awvalid(awvalid), .o_axi_awready(awready),
    .i_axi_wdata(wdata), .i_axi_wstrb(wstrb), .i_axi_wvalid(wvalid), .o_axi_wready(wready),
    .o_axi_bresp(bresp), .o_axi_bvalid(bvalid), .i_axi_bready(bready),
    .i_axi_araddr(araddr), .i_axi_arprot(3'b000), .i_axi_arvalid(arvalid), .o_axi_arready(arready),
    .o_axi_rdata(rdata), .o_axi_rresp(rresp), .o_axi_rvalid(rvalid), .i_axi_rready(rready),
    .o_wb_rst(wb_rst), .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .o_wb_we(wb_we),
    .o_wb_adr(wb_adr), .o_wb_dat(wb_odat), .o_wb_sel(wb_sel),
    .i_wb_dat(wb_idat), .i_wb_ack(wb_ack), .i_wb_err(wb_err), .o_timeout(tmo));

  // 64-bit instance, used only for the word-address mapping read.
  logic [31:0] x_araddr;
  logic [63:0] x_rdata, x_odat, x_idat;
  logic [7:0]  x_sel;
  logic [28:0] x_adr;
  logic [1:0]  x_bresp, x_rresp;
  logic x_arvalid, x_arready, x_rvalid, x_rready, x_awready, x_wready, x_bvalid;
  logic x_wb_rst, x_cyc, x_stb, x_we, x_ack, x_tmo;

  cep_axil2wb_bridge #(.C_AXI_DATA_WIDTH(64), .C_AXI_ADDR_WIDTH(32), .C_WB_TIMEOUT(255)) u_dut64 (
    .clk_i(clk), .rst_ni(rst_ni),
    .i_axi_awaddr(32'h0), .i_axi_awprot(3'b000), .i_axi_awvalid(1'b0), .o_axi_awready(x_awready),
    .i_axi_wdata(64'h0), .i_axi_wstrb(8'h00), .i_axi_wvalid(1'b0), .o_axi_wready(x_wready),
    .o_axi_bresp(x_bresp), .o_axi_bvalid(x_bvalid), .i_axi_bready(1'b1),
    .i_axi_araddr(x_araddr), .i_axi_arprot(3'b000), .i_axi_arvalid(x_arvalid), .o_axi_arready(x_arready),
    .o_axi_rdata(x_rdata), .o_axi_rresp(x_rresp), .o_axi_rvalid(x_rvalid), .i_axi_rready(x_rready),
    .o_wb_rst(x_wb_rst), .o_wb_cyc(x_cyc), .o_wb_stb(x_stb), .o_wb_we(x_we),
    .o_wb_adr(x_adr), .o_wb_dat(x_odat), .o_wb_sel(x_sel),
    .i_wb_dat(x_idat), .i_wb_ack(x_ack), .i_wb_err(1'b0), .o_timeout(x_tmo));

  // Wishbone slave models: ack/err is registered, one cycle after stb is seen.
  // slv_mode: 0 ack, 1 never respond, 2 err+ack together, 3 err only.
  int          slv_mode = 0;
  logic [31:0] slv_dat  = 32'h0;
  logic        ack_q    = 1'b0;
  logic        x_ack_q  = 1'b0;
  always @(posedge clk) ack_q   <= wb_cyc && wb_stb && !ack_q;
  always @(posedge clk) x_ack_q <= x_cyc && x_stb && !x_ack_q;
  assign wb_ack  = ack_q && (slv_mode == 0 || slv_mode == 2);
  assign wb_err  = ack_q && (slv_mode >= 2);
  assign wb_idat = slv_dat;
  assign x_ack   = x_ack_q;
  assign x_idat  = 64'h0123_4567_89AB_CDEF;

  // Bus monitor: cyc/timeout cycle counts and capture of each cycle's start.
  int          cyc_cnt = 0, tmo_cnt = 0, ord_n = 0;
  logic        cyc_prev = 1'b0, cap_we = 1'b0;
  logic [29:0] cap_adr = '0;
  logic [31:0] cap_dat = '0;
  logic [3:0]  cap_sel = '0;
  bit          ord [64];
  always @(negedge clk) begin
    if (wb_cyc) cyc_cnt++;
    if (tmo) tmo_cnt++;
    if (wb_cyc && !cyc_prev) begin
      cap_adr = wb_adr; cap_dat = wb_odat; cap_sel = wb_sel; cap_we = wb_we;
      if (ord_n < 64) begin ord[ord_n] = wb_we; ord_n++; end
    end
    cyc_prev = wb_cyc;
  end

  int checks = 0, errors = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp, output int lat);
    bit aw_done = 0, w_done = 0, awh, wh;
    int n = 0;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1; bready = 0;
    while (!(aw_done && w_done) && n < 40) begin
      awh = awvalid && awready;
      wh  = wvalid && wready;
      @(posedge clk); #1; n++;
      if (awh) begin aw_done = 1; awvalid = 0; end
      if (wh)  begin w_done = 1;  wvalid = 0; end
    end
    chk("write_handshake", {aw_done, w_done}, 2'b11);
    lat = 0;
    while (!bvalid && lat < 60) begin @(posedge clk); #1; lat++; end
    chk("bvalid_seen", bvalid, 1);
    resp = bresp;
    bready = 1; @(posedge clk); #1; bready = 0;
  endtask

  task automatic axi_read(input logic [31:0] a, input int hold,
                          output logic [1:0] resp, output logic [31:0] d, output int lat);
    bit arh;
    int n = 0;
    araddr = a; arvalid = 1; rready = 0;
    while (arvalid && n < 40) begin
      arh = arready;
      @(posedge clk); #1; n++;
      if (arh) arvalid = 0;
    end
    chk("read_handshake", arvalid, 0);
    lat = 0;
    while (!rvalid && lat < 60) begin @(posedge clk); #1; lat++; end
    chk("rvalid_seen", rvalid, 1);
    resp = rresp; d = rdata;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk($sformatf("rvalid_hold_%0d", i), rvalid, 1);
      chk($sformatf("rdata_hold_%0d", i), rdata, d);
      chk($sformatf("rresp_hold_%0d", i), rresp, resp);
    end
    rready = 1; @(posedge clk); #1; rready = 0;
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr, data;
    logic [3:0]  strb;
    int          mode;
    logic [31:0] sdat;
    int          hold;
    logic [1:0]  resp;
    logic [31:0] rdata;
    int          lat, ncyc, ntmo;
    logic [29:0] adr;
    logic [3:0]  sel;
  } vec_t;
  vec_t vt [8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [1:0]  r;
    logic [31:0] d;
    int          lat, n;

    //          wr addr          data          strb mode sdat         hold resp   rdata         lat ncyc tmo adr     sel
    vt[0] = '{1, 32'h0000_0010, 32'hDEADBEEF, 4'hF, 0, 32'h0,        0, 2'b00, 32'h0,        3,  2,  0, 30'h4,  4'hF};
    vt[1] = '{0, 32'h0000_0008, 32'h0,        4'h0, 0, 32'h12345678, 5, 2'b00, 32'h12345678, 3,  2,  0, 30'h2,  4'hF};
    vt[2] = '{1, 32'h0000_0020, 32'hCAFEF00D, 4'hF, 2, 32'h0,        0, 2'b10, 32'h0,        3,  2,  0, 30'h8,  4'hF};
    vt[3] = '{1, 32'h0000_0024, 32'h11112222, 4'h0, 0, 32'h0,        0, 2'b00, 32'h0,        1,  0,  0, 30'h0,  4'h0};
    vt[4] = '{0, 32'h0000_0040, 32'h0,        4'h0, 1, 32'hFFFF0000, 0, 2'b10, 32'h0,        17, 16, 1, 30'h10, 4'hF};
    vt[5] = '{0, 32'h0000_0044, 32'h0,        4'h0, 0, 32'hA5A55A5A, 0, 2'b00, 32'hA5A55A5A, 3,  2,  0, 30'h11, 4'hF};
    vt[6] = '{1, 32'h0000_00FC, 32'h00ABCD00, 4'h6, 0, 32'h0,        0, 2'b00, 32'h0,        3,  2,  0, 30'h3F, 4'h6};
    vt[7] = '{0, 32'h0000_0013, 32'h0,        4'h0, 3, 32'h77777777, 0, 2'b10, 32'h0,        3,  2,  0, 30'h4,  4'hF};

    awaddr = 0; wdata = 0; wstrb = 0; araddr = 0;
    awvalid = 0; wvalid = 0; arvalid = 0; bready = 0; rready = 0;
    x_araddr = 0; x_arvalid = 0; x_rready = 0;
    rst_ni = 0;
    repeat (3) @(posedge clk); #1;
    chk("reset_wb_rst", wb_rst, 1);
    chk("reset_readies", {awready, wready, arready}, 3'b000);
    chk("reset_valids", {bvalid, rvalid, wb_cyc, wb_stb, tmo}, 5'b0);
    rst_ni = 1;
    @(posedge clk); #1;
    chk("wb_rst_edge1", wb_rst, 1);
    chk("ready_edge1", awready, 0);
    @(posedge clk); #1;
    chk("wb_rst_edge2", wb_rst, 0);
    chk("ready_edge2", {awready, wready, arready}, 3'b111);

    for (int i = 0; i < 8; i++) begin
      slv_mode = vt[i].mode; slv_dat = vt[i].sdat;
      cyc_cnt = 0; tmo_cnt = 0;
      if (vt[i].wr) axi_write(vt[i].addr, vt[i].data, vt[i].strb, r, lat);
      else          axi_read(vt[i].addr, vt[i].hold, r, d, lat);
      repeat (2) @(posedge clk); #1;
      chk($sformatf("v%0d_resp", i), r, vt[i].resp);
      chk($sformatf("v%0d_latency", i), lat, vt[i].lat);
      chk($sformatf("v%0d_cyc_cycles", i), cyc_cnt, vt[i].ncyc);
      chk($sformatf("v%0d_timeout_pulses", i), tmo_cnt, vt[i].ntmo);
      if (!vt[i].wr) chk($sformatf("v%0d_rdata", i), d, vt[i].rdata);
      if (vt[i].ncyc != 0) begin
        chk($sformatf("v%0d_wb_adr", i), cap_adr, vt[i].adr);
        chk($sformatf("v%0d_wb_sel", i), cap_sel, vt[i].sel);
        chk($sformatf("v%0d_wb_we", i), cap_we, vt[i].wr);
        if (vt[i].wr) chk($sformatf("v%0d_wb_dat", i), cap_dat, vt[i].data);
      end
      $display("vec %0d: %s addr=0x%0h resp=%0d lat=%0d cyc=%0d", i, vt[i].wr ? "WR" : "RD",
               vt[i].addr, r, lat, cyc_cnt);
    end

    // Reset dropped while a read cycle is outstanding.
    slv_mode = 1;
    chk("rst_pre_arready", arready, 1);
    araddr = 32'h30; arvalid = 1;
    @(posedge clk); #1; arvalid = 0;
    n = 0;
    while (!wb_cyc && n < 10) begin @(posedge clk); #1; n++; end
    chk("rst_pre_cyc", wb_cyc, 1);
    @(posedge clk); #3;
    rst_ni = 0; #1;
    chk("rst_mid_cyc_stb", {wb_cyc, wb_stb}, 2'b00);
    chk("rst_mid_rvalid", rvalid, 0);
    chk("rst_mid_wb_rst", wb_rst, 1);
    chk("rst_mid_arready", arready, 0);
    repeat (2) @(posedge clk); #1;
    rst_ni = 1;
    @(posedge clk); #1;
    chk("rst_rel_edge1", wb_rst, 1);
    @(posedge clk); #1;
    chk("rst_rel_edge2", wb_rst, 0);
    chk("rst_rel_no_cyc", {wb_cyc, rvalid}, 2'b00);
    slv_mode = 0; slv_dat = 32'h0BADF00D;
    axi_read(32'h30, 0, r, d, lat);
    chk("rst_after_rresp", r, 2'b00);
    chk("rst_after_rdata", d, 32'h0BADF00D);
    $display("post-reset read: resp=%0d rdata=0x%0h", r, d);

    // Write and read pending together from reset with all channels kept busy.
    rst_ni = 0;
    repeat (2) @(posedge clk); #1;
    awaddr = 32'h100; wdata = 32'h55AA55AA; wstrb = 4'hF; araddr = 32'h200;
    awvalid = 1; wvalid = 1; arvalid = 1; bready = 1; rready = 1;
    slv_mode = 0; ord_n = 0;
    rst_ni = 1;
    repeat (70) @(posedge clk); #1;
    awvalid = 0; wvalid = 0; arvalid = 0;
    repeat (20) @(posedge clk); #1;
    bready = 0; rready = 0;
    chk("order_count_ge8", ord_n >= 8, 1);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("order_%0d", i), ord[i], (i % 2 == 0));
      $display("order %0d: %s", i, ord[i] ? "W" : "R");
    end

    // 64-bit instance: byte address 0x18 is word 3.
    x_araddr = 32'h18; x_arvalid = 1;
    n = 0;
    while (x_arvalid && n < 20) begin
      if (x_arready) begin @(posedge clk); #1; x_arvalid = 0; end
      else begin @(posedge clk); #1; end
      n++;
    end
    n = 0;
    while (!x_cyc && n < 10) begin @(posedge clk); #1; n++; end
    chk("x64_cyc", x_cyc, 1);
    chk("x64_adr", x_adr, 29'h3);
    chk("x64_sel", x_sel, 8'hFF);
    n = 0;
    while (!x_rvalid && n < 10) begin @(posedge clk); #1; n++; end
    chk("x64_rvalid", x_rvalid, 1);
    chk("x64_rdata", x_rdata, 64'h0123_4567_89AB_CDEF);
    chk("x64_rresp", x_rresp, 2'b00);
    $display("x64 read: adr=0x%0h rdata=0x%0h", x_adr, x_rdata);
    x_rready = 1; @(posedge clk); #1; x_rready = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
